// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor (a - b - borrow_in), LSB first.
// One full-subtractor cell is shared across WIDTH shift cycles; a start/busy/done
// handshake brackets each operation.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Registered state
   state_t           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_sd;
   logic             r_br;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_out;

   // Next-state values
   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_sa_nxt;
   logic [WIDTH-1:0] w_sb_nxt;
   logic [WIDTH-1:0] w_sd_nxt;
   logic             w_br_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_diff_nxt;
   logic             w_borrow_out_nxt;

   // Full-subtractor cell
   logic             w_d;
   logic             w_br_cell;
   logic [WIDTH-1:0] w_sd_shift;

   // Single full-subtractor bit: difference and outgoing borrow
   always_comb begin
      w_d        = r_sa[0] ^ r_sb[0] ^ r_br;
      w_br_cell  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
      w_sd_shift = {w_d, r_sd[WIDTH-1:1]};
   end

   // Next-state and datapath update logic
   always_comb begin
      w_state_nxt      = r_state;
      w_sa_nxt         = r_sa;
      w_sb_nxt         = r_sb;
      w_sd_nxt         = r_sd;
      w_br_nxt         = r_br;
      w_cnt_nxt        = r_cnt;
      w_diff_nxt       = r_diff;
      w_borrow_out_nxt = r_borrow_out;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_sa_nxt    = a;
               w_sb_nxt    = b;
               w_br_nxt    = borrow_in;
               w_cnt_nxt   = '0;
               w_sd_nxt    = '0;
               w_state_nxt = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            w_sa_nxt  = {1'b0, r_sa[WIDTH-1:1]};
            w_sb_nxt  = {1'b0, r_sb[WIDTH-1:1]};
            w_sd_nxt  = w_sd_shift;
            w_br_nxt  = w_br_cell;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            // Results are published only on the final bit, never partially
            if (r_cnt == LAST_BIT) begin
               w_diff_nxt       = w_sd_shift;
               w_borrow_out_nxt = w_br_cell;
               w_state_nxt      = ST_DONE;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_sa         <= '0;
         r_sb         <= '0;
         r_sd         <= '0;
         r_br         <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sa         <= w_sa_nxt;
         r_sb         <= w_sb_nxt;
         r_sd         <= w_sd_nxt;
         r_br         <= w_br_nxt;
         r_cnt        <= w_cnt_nxt;
         r_diff       <= w_diff_nxt;
         r_borrow_out <= w_borrow_out_nxt;
      end
   end

   // Handshake status decoded straight from the state register
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// against an arithmetic reference ({1'b0,a} - b - bin, bit WIDTH = borrow).
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   int checks;
   int errors;

   logic [WIDTH-1:0] prev_diff;
   logic             prev_bo;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: unsigned subtraction in WIDTH+1 bits, top bit is the borrow
   function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] ra,
                                              input logic [WIDTH-1:0] rb,
                                              input logic rbin);
      return {1'b0, ra} - {1'b0, rb} - (WIDTH+1)'(rbin);
   endfunction

   // One full operation; caller is one step after an edge with the DUT idle.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tbin, input string name);
      logic [WIDTH:0] exp;
      exp       = ref_sub(ta, tb, tbin);
      start     = 1'b1;
      a         = ta;
      b         = tb;
      borrow_in = tbin;
      @(posedge clk); #1;
      // Operands are free to change once accepted
      start     = 1'b0;
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      borrow_in = 1'($urandom);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
      end
      for (int k = 1; k < int'(WIDTH); k++) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff || borrow_out !== prev_bo) begin
            errors++;
            $display("FAIL %s shift%0d: busy=%b done=%b diff=%h bo=%b required busy=1 done=0 diff=%h bo=%b",
                     name, k, busy, done, diff, borrow_out, prev_diff, prev_bo);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s done_pulse: done=%b busy=%b required 1 1", name, done, busy);
      end
      checks++;
      if (diff !== exp[WIDTH-1:0] || borrow_out !== exp[WIDTH]) begin
         errors++;
         $display("FAIL %s result: diff=%h bo=%b required diff=%h bo=%b (a=%h b=%h bin=%b)",
                  name, diff, borrow_out, exp[WIDTH-1:0], exp[WIDTH], ta, tb, tbin);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== exp[WIDTH-1:0] || borrow_out !== exp[WIDTH]) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b diff=%h bo=%b required 0 0 %h %b",
                  name, done, busy, diff, borrow_out, exp[WIDTH-1:0], exp[WIDTH]);
      end
      prev_diff = exp[WIDTH-1:0];
      prev_bo   = exp[WIDTH];
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b diff=%h bo=%b required 0 0 00 0", busy, done, diff, borrow_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      prev_diff = '0;
      prev_bo   = 1'b0;
   endtask

   task automatic test_directed();
      run_op(8'h05, 8'h03, 1'b0, "d_05_03");
      run_op(8'h03, 8'h05, 1'b0, "d_03_05");
      run_op(8'h00, 8'h00, 1'b1, "d_00_00_b");
      run_op(8'hFF, 8'hFF, 1'b0, "d_FF_FF");
      run_op(8'h80, 8'h01, 1'b0, "d_80_01");
   endtask

   // Start pulses during SHIFT and DONE must not disturb the running operation
   task automatic test_ignore_start();
      int dcount;
      dcount    = 0;
      start     = 1'b1;
      a         = 8'h10;
      b         = 8'h01;
      borrow_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 21; cyc++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dcount++;
         if (cyc == 2) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'h55;
         end
         if (cyc == 3) start = 1'b0;
         if (cyc == 8) begin
            checks++;
            if (done !== 1'b1 || diff !== 8'h0F || borrow_out !== 1'b0) begin
               errors++;
               $display("FAIL ignore_done: done=%b diff=%h bo=%b required 1 0f 0", done, diff, borrow_out);
            end
            start = 1'b1;
         end
         if (cyc == 9) start = 1'b0;
      end
      checks++;
      if (dcount != 1 || busy !== 1'b0 || diff !== 8'h0F || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL ignore_final: dones=%0d busy=%b diff=%h bo=%b required 1 0 0f 0",
                  dcount, busy, diff, borrow_out);
      end
      prev_diff = 8'h0F;
      prev_bo   = 1'b0;
   endtask

   // Reset during SHIFT aborts without a done pulse
   task automatic test_reset_abort();
      int dcount;
      dcount    = 0;
      start     = 1'b1;
      a         = 8'h03;
      b         = 8'h05;
      borrow_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b diff=%h bo=%b required 0 0 00 0", busy, done, diff, borrow_out);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dcount++;
      end
      checks++;
      if (dcount != 0) begin
         errors++;
         $display("FAIL abort_quiet: active_cycles=%0d required 0", dcount);
      end
      prev_diff = '0;
      prev_bo   = 1'b0;
      run_op(8'h05, 8'h03, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 1000; n++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
